// File: rtl/wb_sha_bridge_pkg.sv
// Shared types and constants for the Wishbone to SHA-256 register bridge.
// Optional error reporting is enabled with WB_SHA_BRIDGE_ERR_EN.
package wb_sha_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      ACK
   } state_t;

   localparam logic [31:0] DEF_BASE = 32'h3000_0000;
   localparam logic [31:0] DEF_MASK = 32'hFFFF_FC00;
   localparam int          CORE_AW  = 8;
   localparam logic [3:0]  FULL_SEL = 4'hF;

   function automatic logic addr_hit(
      input logic [31:0] adr,
      input logic [31:0] base,
      input logic [31:0] mask
   );
      return ((adr ^ base) & mask) == 32'h0;
   endfunction

endpackage

// File: rtl/wb_sha_bridge_if.sv
// Wishbone classic slave bundle seen by the SHA bridge.
// wbs_err_o exists only when WB_SHA_BRIDGE_ERR_EN is defined.
interface wb_sha_bridge_if;

   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
`ifdef WB_SHA_BRIDGE_ERR_EN
   logic        wbs_err_o;
`endif

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
      input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
`ifdef WB_SHA_BRIDGE_ERR_EN
      output wbs_err_o,
`endif
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i,
      output wbs_sel_i, wbs_adr_i, wbs_dat_i,
`ifdef WB_SHA_BRIDGE_ERR_EN
      input  wbs_err_o,
`endif
      input  wbs_ack_o, wbs_dat_o
   );

endinterface

// File: rtl/wb_sha_bridge.sv
// Wishbone classic slave to single-cycle cs/we SHA-256 core register port.
// Define WB_SHA_BRIDGE_ERR_EN to report misses, partial writes and core errors on wbs_err_o.
module wb_sha_bridge
   import wb_sha_bridge_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = DEF_BASE,
   parameter logic [31:0] ADDR_MASK = DEF_MASK,
   parameter int          READ_LAT  = 1
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   wb_sha_bridge_if.slave     wb,
   output logic               core_cs,
   output logic               core_we,
   output logic [CORE_AW-1:0] core_address,
   output logic [31:0]        core_write_data,
   input  logic [31:0]        core_read_data,
   input  logic               core_error
);

   state_t             state, state_n;
   logic [1:0]         cnt, cnt_n;
   logic               abort, abort_n;
   logic               cs_n, we_n, ack_n;
   logic [CORE_AW-1:0] adr_n;
   logic [31:0]        wd_n, dat_n;
   logic               req, hit, bad, live, resp;

`ifdef WB_SHA_BRIDGE_ERR_EN
   logic err_n;
   assign resp = wb.wbs_ack_o | wb.wbs_err_o;
`else
   logic unused_err;
   assign unused_err = core_error;
   assign resp = wb.wbs_ack_o;
`endif

   assign req  = wb.wbs_cyc_i & wb.wbs_stb_i & ~resp;
   assign hit  = addr_hit(wb.wbs_adr_i, ADDR_BASE, ADDR_MASK);
   assign bad  = ~hit | (wb.wbs_we_i & (wb.wbs_sel_i != FULL_SEL));
   // A dropped cycle anywhere after issue must not be acked later.
   assign live = wb.wbs_cyc_i & wb.wbs_stb_i & ~abort;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      abort_n = abort;
      cs_n    = 1'b0;
      we_n    = core_we;
      adr_n   = core_address;
      wd_n    = core_write_data;
      ack_n   = 1'b0;
      dat_n   = wb.wbs_dat_o;
`ifdef WB_SHA_BRIDGE_ERR_EN
      err_n   = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (req && bad) begin
               state_n = ACK;
               dat_n   = 32'h0;
`ifdef WB_SHA_BRIDGE_ERR_EN
               err_n   = 1'b1;
`else
               ack_n   = 1'b1;
`endif
            end else if (req) begin
               state_n = ISSUE;
               cs_n    = 1'b1;
               we_n    = wb.wbs_we_i;
               adr_n   = wb.wbs_adr_i[CORE_AW+1:2];
               wd_n    = wb.wbs_dat_i;
               abort_n = 1'b0;
            end
         end
         ISSUE: begin
            state_n = WAIT;
            cnt_n   = 2'(READ_LAT - 1);
            if (!wb.wbs_cyc_i) abort_n = 1'b1;
         end
         WAIT: begin
            if (!wb.wbs_cyc_i) abort_n = 1'b1;
            if (cnt == 2'd0) begin
               state_n = ACK;
               if (live) begin
                  dat_n = core_we ? 32'h0 : core_read_data;
`ifdef WB_SHA_BRIDGE_ERR_EN
                  err_n = core_error;
                  ack_n = ~core_error;
`else
                  ack_n = 1'b1;
`endif
               end
            end else begin
               cnt_n = cnt - 2'd1;
            end
         end
         ACK: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state           <= IDLE;
         cnt             <= 2'd0;
         abort           <= 1'b0;
         core_cs         <= 1'b0;
         core_we         <= 1'b0;
         core_address    <= '0;
         core_write_data <= 32'h0;
         wb.wbs_ack_o    <= 1'b0;
         wb.wbs_dat_o    <= 32'h0;
`ifdef WB_SHA_BRIDGE_ERR_EN
         wb.wbs_err_o    <= 1'b0;
`endif
      end else begin
         state           <= state_n;
         cnt             <= cnt_n;
         abort           <= abort_n;
         core_cs         <= cs_n;
         core_we         <= we_n;
         core_address    <= adr_n;
         core_write_data <= wd_n;
         wb.wbs_ack_o    <= ack_n;
         wb.wbs_dat_o    <= dat_n;
`ifdef WB_SHA_BRIDGE_ERR_EN
         wb.wbs_err_o    <= err_n;
`endif
      end
   end

endmodule
